// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial word transmitter.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int DATA_BITS            = 8;
    localparam int WORD_BYTES           = 2;
    localparam int WORD_W               = DATA_BITS * WORD_BYTES;
    localparam int DEFAULT_CLKS_PER_BIT = 217;

    localparam logic BYTE_LOW  = 1'b0;
    localparam logic BYTE_HIGH = 1'b1;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Synchronous word FIFO, depth 2**AW; full/empty are registered from the next count.
module serial_tx_fifo #(
    parameter int AW = 2,
    parameter int DW = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          wr,
    input  logic          rd,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_q;
    logic          empty_q;

    always_comb begin
        count_d = count_q + CW'(wr) - CW'(rd);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (wr) wptr_q <= wptr_q + 1'b1;
            if (rd) rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage needs no reset; contents are only read behind a valid count.
    always_ff @(posedge Clock) begin
        if (wr) mem[wptr_q] <= din;
    end

    assign dout  = mem[rptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/serial_word_tx.sv
// 16-bit word to UART (8N1, low byte first) transmitter with input FIFO.
// Define SERIAL_WORD_TX_PARITY_EN to insert an even parity bit (8E1).
//
// state  | meaning
// IDLE   | line high, pop next word when FIFO not empty
// START  | start bit (low)
// DATA   | 8 data bits, LSB first
// PARITY | even parity of the byte (parity build only)
// STOP   | stop bit (high); low byte loops to START, high byte to IDLE
module serial_word_tx
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_AW      = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              SerialWrite,
    input  logic [WORD_W-1:0] SerialData,
    output logic              Tx,
    output logic              Full,
    output logic              Busy,
    output logic              Overflow
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int CW     = FIFO_AW + 1;

    tx_state_e           state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                sel_q, sel_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;

    logic [WORD_W-1:0]    fifo_dout;
    logic [FIFO_AW:0]     fifo_count;
    logic [FIFO_AW:0]     count_d;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 wr_ok;
    logic                 baud_done;
    logic [DATA_BITS-1:0] cur_byte;

    // A pop frees a slot in the same cycle, so a write at full is still taken.
    assign pop   = (state_q == ST_IDLE) && !fifo_empty;
    assign wr_ok = SerialWrite && (!fifo_full || pop);

    serial_tx_fifo #(
        .AW (FIFO_AW),
        .DW (WORD_W)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .wr    (wr_ok),
        .rd    (pop),
        .din   (SerialData),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign cur_byte  = (sel_q == BYTE_HIGH) ? word_q[WORD_W-1:DATA_BITS]
                                            : word_q[DATA_BITS-1:0];

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sel_d   = sel_q;
        word_d  = word_q;
        unique case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (pop) begin
                    word_d  = fifo_dout;
                    sel_d   = BYTE_LOW;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (sel_q == BYTE_LOW) begin
                        sel_d   = BYTE_HIGH;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Tx is derived from the next state so the pin itself is a flop output.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = cur_byte[bit_d];
`ifdef SERIAL_WORD_TX_PARITY_EN
            ST_PARITY: tx_d = even_parity(cur_byte);
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_comb begin
        count_d = fifo_count + CW'(wr_ok) - CW'(pop);
        busy_d  = (count_d != '0) || (state_d != ST_IDLE);
        ovf_d   = ovf_q || (SerialWrite && !wr_ok);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sel_q   <= BYTE_LOW;
            word_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sel_q   <= sel_d;
            word_q  <= word_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Tx       = tx_q;
    assign Full     = fifo_full;
    assign Busy     = busy_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Randomized bench for serial_word_tx against a word-level timing model.
module tb_serial_word_tx;

    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
`ifdef SERIAL_WORD_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int BYTE_T = NBITS * CPB;
    localparam int FRAME  = 2 * BYTE_T;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        SerialWrite = 1'b0;
    logic [15:0] SerialData = '0;
    logic        Tx, Full, Busy, Overflow;

    int errors = 0;
    int checks = 0;

    // model state
    int          e = 0;
    int          last_pop = -(FRAME + 1);
    logic [15:0] q[$];
    logic [15:0] cur_word = '0;
    logic        m_ovf = 1'b0;

    serial_word_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .SerialWrite (SerialWrite),
        .SerialData  (SerialData),
        .Tx          (Tx),
        .Full        (Full),
        .Busy        (Busy),
        .Overflow    (Overflow)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    function automatic logic exp_tx();
        int          off;
        int          slot;
        logic [7:0]  b;
        off = e - last_pop;
        if (off >= FRAME) return 1'b1;
        b    = (off / BYTE_T == 0) ? cur_word[7:0] : cur_word[15:8];
        slot = (off % BYTE_T) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (NBITS == 11 && slot == 9) return ^b;
        return 1'b1;
    endfunction

    // Transmitter is idle before edge e once the previous word's frame has elapsed.
    task automatic model_edge(input logic wr, input logic [15:0] data);
        logic pop;
        e++;
        pop = (e >= last_pop + FRAME + 1) && (q.size() > 0);
        if (pop) begin
            cur_word = q.pop_front();
            last_pop = e;
        end
        if (wr) begin
            if (q.size() < DEPTH) q.push_back(data);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_pop = e - FRAME - 1;
        m_ovf = 1'b0;
    endtask

    task automatic compare_all();
        check("tx",       Tx,       exp_tx());
        check("busy",     Busy,     (q.size() != 0) || (e - last_pop < FRAME));
        check("full",     Full,     q.size() == DEPTH);
        check("overflow", Overflow, m_ovf);
    endtask

    // Called at a negedge: drive, clock, update model, then sample at the next negedge.
    task automatic step(input logic wr, input logic [15:0] data);
        SerialWrite = wr;
        SerialData  = data;
        @(posedge Clock);
        model_edge(wr, data);
        @(negedge Clock);
        SerialWrite = 1'b0;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0);
    endtask

    task automatic drain();
        int guard = 0;
        while ((q.size() != 0 || e - last_pop < FRAME) && guard < 20 * FRAME) begin
            step(1'b0, 16'h0);
            guard++;
        end
        idle(2);
    endtask

    initial begin
        int fall_edge;
        int busy_edge;
        int start_e;

        // reset state
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_tx", Tx, 1'b1);
        check("rst_busy", Busy, 1'b0);
        check("rst_full", Full, 1'b0);
        check("rst_ovf", Overflow, 1'b0);
        Reset = 1'b1;
        idle(3);

        // single word: Tx falls on the second edge, Busy drops after 2*frame+2 edges
        start_e   = e;
        fall_edge = -1;
        busy_edge = -1;
        step(1'b1, 16'hA55A);
        for (int i = 0; i < FRAME + 10; i++) begin
            if (fall_edge < 0 && Tx == 1'b0) fall_edge = e - start_e;
            if (busy_edge < 0 && Busy == 1'b0) busy_edge = e - start_e;
            step(1'b0, 16'h0);
        end
        check("single_tx_fall_edge", fall_edge, 2);
        check("single_busy_drop_edge", busy_edge, FRAME + 2);
        idle(2);

        // reset mid-frame, during DATA of 0x1234 with more words queued
        step(1'b1, 16'h1234);
        step(1'b1, 16'h5678);
        step(1'b1, 16'h9ABC);
        idle(3 * CPB);
        Reset = 1'b0;
        #1;
        check("midrst_tx", Tx, 1'b1);
        check("midrst_busy", Busy, 1'b0);
        check("midrst_full", Full, 1'b0);
        @(negedge Clock);
        Reset = 1'b1;
        model_reset();
        idle(2);
        step(1'b1, 16'hC3E1);
        drain();

        // burst of four fills the FIFO behind the first popped word
        step(1'b1, 16'h0001);
        step(1'b1, 16'h0002);
        step(1'b1, 16'h0003);
        step(1'b1, 16'h0004);
        step(1'b1, 16'h0005);
        check("burst_full", Full, 1'b1);
        check("burst_no_ovf", Overflow, 1'b0);
        drain();

        // simultaneous write and pop while full
        step(1'b1, 16'h1111);
        step(1'b1, 16'h2222);
        step(1'b1, 16'h3333);
        step(1'b1, 16'h4444);
        step(1'b1, 16'h5555);
        while (e + 1 < last_pop + FRAME + 1) step(1'b0, 16'h0);
        step(1'b1, 16'h6666);
        check("wrpop_full", Full, 1'b1);
        check("wrpop_no_ovf", Overflow, 1'b0);
        check("wrpop_last_queued", q[q.size()-1], 16'h6666);
        drain();

        // six back-to-back: sixth dropped, overflow sticky
        for (int i = 0; i < 6; i++) step(1'b1, 16'(16'h0A00 + i));
        check("ovf_set", Overflow, 1'b1);
        drain();
        check("ovf_sticky", Overflow, 1'b1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 6), 16'($urandom));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
